// File: rtl/frame_pkg.sv
// frame_pkg: shared types and defaults for the frame_tx block.
// The optional checksum byte is enabled by defining FRAME_TX_CHECKSUM_EN,
// which also adds the ST_CHECK state to the sequencer encoding.
package frame_pkg;

  // Start-of-frame character sent ahead of the payload ('A').
  localparam logic [7:0] HEADER_BYTE_DEF = 8'h41;

  // Number of payload bytes carried in every frame.
  localparam int FRAME_LEN_DEF = 16;

  // Power-up contents of every payload buffer slot.
  localparam logic [7:0] BUF_INIT = 8'h00;

  // Frame sequencer states; the state names the byte currently on the wire.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
`ifdef FRAME_TX_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE
  } frame_state_t;

endpackage

// File: rtl/txuart.sv
// txuart: single-byte 8N1 serializer (start bit, 8 data bits LSB first,
// stop bit), each bit CLKS_PER_BAUD cycles long.
// o_busy drops during the final cycle of the stop bit, so a byte offered
// on that cycle starts its start bit on the very next cycle (no idle gap).
module txuart
  import frame_pkg::*;
#(
  parameter int CLKS_PER_BAUD = 217
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_TX
);

  localparam int              BAUD_W    = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BAUD - 1);
  localparam logic [3:0]      BIT_LAST_DATA = 4'd8;
  localparam logic [3:0]      BIT_STOP      = 4'd9;

  logic              busy_reg;
  logic [BAUD_W-1:0] baud_cnt_reg;
  logic [3:0]        bit_cnt_reg;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]        shift_reg;
  logic              tx_reg;
  logic              baud_tick;
  logic              stop_end;

  assign baud_tick = busy_reg && (baud_cnt_reg == BAUD_LAST);
  assign stop_end  = baud_tick && (bit_cnt_reg == BIT_STOP);
  assign o_busy    = busy_reg && !stop_end;
  assign o_TX      = tx_reg;

  // Bit timing and shift-out; a new byte may be loaded on the last stop-bit cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_reg     <= 1'b0;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else if (i_valid && !o_busy) begin
      busy_reg     <= 1'b1;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= i_data;
      tx_reg       <= 1'b0;
    end else if (stop_end) begin
      busy_reg     <= 1'b0;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      tx_reg       <= 1'b1;
    end else if (baud_tick) begin
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= bit_cnt_reg + 4'd1;
      if (bit_cnt_reg == BIT_LAST_DATA) begin
        tx_reg <= 1'b1;
      end else begin
        tx_reg    <= shift_reg[0];
        shift_reg <= shift_reg >> 1;
      end
    end else if (busy_reg) begin
      baud_cnt_reg <= baud_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/frame_tx.sv
// frame_tx: sends HEADER_BYTE followed by FRAME_LEN buffered payload bytes
// over a UART line, back-to-back, on a single i_send request.
// Optional: define FRAME_TX_CHECKSUM_EN to append the XOR of the payload
// bytes as one extra byte after the payload.
module frame_tx
  import frame_pkg::*;
#(
  parameter int         CLKS_PER_BAUD = 217,
  parameter logic [7:0] HEADER_BYTE   = HEADER_BYTE_DEF,
  parameter int         FRAME_LEN     = FRAME_LEN_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic       i_send,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_TX
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  frame_state_t state_reg;
  logic [3:0]   idx_reg;       // payload byte currently on the wire
  logic         busy_reg;
  logic         done_reg;

  // Payload store; contents survive reset and power up to BUF_INIT.
  logic [7:0]   buf_mem [0:FRAME_LEN-1] = '{default: BUF_INIT};
  logic [7:0]   rd_data_reg;
  logic [3:0]   rd_addr;
  logic         wr_ok;

  logic         uart_valid;
  logic [7:0]   uart_data;
  logic         uart_busy;
  logic         uart_accept;

`ifdef FRAME_TX_CHECKSUM_EN
  logic [7:0]   csum_reg;      // XOR of payload bytes handed to the serializer
`endif

  // Writes are locked out for the whole frame and for out-of-range slots.
  assign wr_ok = i_wr_en && !busy_reg && (32'(i_wr_addr) < 32'(FRAME_LEN));

  // Buffer write port.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      buf_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Prefetch the next payload byte; it is needed a whole byte time later.
  assign rd_addr = (state_reg == ST_PAYLOAD) ? idx_reg + 4'd1 : 4'd0;

  // Registered buffer read port.
  always_ff @(posedge CLK) begin
    rd_data_reg <= buf_mem[rd_addr];
  end

  // Offer the following byte to the serializer while the current one is sent.
  always_comb begin
    uart_valid = 1'b0;
    uart_data  = HEADER_BYTE;
    case (state_reg)
      ST_IDLE: begin
        uart_valid = i_send;
        uart_data  = HEADER_BYTE;
      end
      ST_HEADER: begin
        uart_valid = 1'b1;
        uart_data  = rd_data_reg;
      end
      ST_PAYLOAD: begin
        if (idx_reg != LAST_IDX) begin
          uart_valid = 1'b1;
          uart_data  = rd_data_reg;
        end else begin
`ifdef FRAME_TX_CHECKSUM_EN
          uart_valid = 1'b1;
          uart_data  = csum_reg;
`else
          uart_valid = 1'b0;
`endif
        end
      end
      default: begin
        uart_valid = 1'b0;
      end
    endcase
  end

  assign uart_accept = uart_valid && !uart_busy;

  // Frame sequencer with registered busy/done outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef FRAME_TX_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (uart_accept) begin
            state_reg <= ST_HEADER;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
`ifdef FRAME_TX_CHECKSUM_EN
            csum_reg  <= '0;
`endif
          end
        end
        ST_HEADER: begin
          if (uart_accept) begin
            state_reg <= ST_PAYLOAD;
            idx_reg   <= '0;
`ifdef FRAME_TX_CHECKSUM_EN
            csum_reg  <= csum_reg ^ rd_data_reg;
`endif
          end
        end
        ST_PAYLOAD: begin
          if (idx_reg != LAST_IDX) begin
            if (uart_accept) begin
              idx_reg <= idx_reg + 4'd1;
`ifdef FRAME_TX_CHECKSUM_EN
              csum_reg <= csum_reg ^ rd_data_reg;
`endif
            end
          end else begin
`ifdef FRAME_TX_CHECKSUM_EN
            if (uart_accept) begin
              state_reg <= ST_CHECK;
            end
`else
            if (!uart_busy) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
`endif
          end
        end
`ifdef FRAME_TX_CHECKSUM_EN
        ST_CHECK: begin
          if (!uart_busy) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = busy_reg;
  assign o_done = done_reg;

  txuart #(
    .CLKS_PER_BAUD(CLKS_PER_BAUD)
  ) u_txuart (
    .CLK    (CLK),
    .RST    (RST),
    .i_valid(uart_valid),
    .i_data (uart_data),
    .o_busy (uart_busy),
    .o_TX   (o_TX)
  );

endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: directed, table-driven bench for frame_tx with a UART
// receiver that decodes o_TX independently of the design.
module tb_frame_tx;

  localparam int BAUD = 4;
  localparam int FLEN = 16;
`ifdef FRAME_TX_CHECKSUM_EN
  localparam int NBYTES = FLEN + 2;
`else
  localparam int NBYTES = FLEN + 1;
`endif
  localparam int FRAME_CYC = NBYTES * 10 * BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       send = 1'b0;
  logic       busy;
  logic       done;
  logic       tx;

  frame_tx #(
    .CLKS_PER_BAUD(BAUD),
    .HEADER_BYTE  (8'h41),
    .FRAME_LEN    (FLEN)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .i_wr_en  (wr_en),
    .i_wr_addr(wr_addr),
    .i_wr_data(wr_data),
    .i_send   (send),
    .o_busy   (busy),
    .o_done   (done),
    .o_TX     (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    int         wire_pos;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t       vecs [5];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc_cnt = 0;
  int         done_cnt = 0;
  int         overlap_cnt = 0;
  int         rx_frame_err = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_buf [FLEN];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (done === 1'b1 && busy === 1'b1) overlap_cnt <= overlap_cnt + 1;
  end

  // UART receiver: samples each bit two cycles into its bit period.
  initial begin : rx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        repeat (BAUD + 1) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          b[k] = tx;
          repeat (BAUD) @(negedge clk);
        end
        if (tx !== 1'b1) rx_frame_err++;
        rx_q.push_back(b);
        repeat (BAUD - 2) @(negedge clk);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wr_slot(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    exp_buf[a] = d;
  endtask

  // Pulse i_send (optionally with a same-cycle write) and check the start bit.
  task automatic start_send(input bit w, input logic [3:0] a, input logic [7:0] d, output int t0);
    @(negedge clk);
    send = 1'b1;
    if (w) begin
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      exp_buf[a] = d;
    end
    @(posedge clk);
    #1;
    send = 1'b0;
    wr_en = 1'b0;
    t0 = cyc_cnt;
    chk("start_bit_tx", 32'(tx), 32'd0);
    chk("busy_rise", 32'(busy), 32'd1);
  endtask

  // Latency counts the i_send cycle as cycle 0.
  task automatic wait_done(input int t0, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < FRAME_CYC + 200 && !got; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        got = 1'b1;
        lat = cyc_cnt - t0 + 1;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int lat);
    logic [7:0] x;
    x = 8'h00;
    $display("frame %s: %0d bytes, latency %0d cycles", tag, rx_q.size(), lat);
    chk({tag, "_latency"}, 32'(lat), 32'(FRAME_CYC + 1));
    chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(NBYTES));
    chk({tag, "_header"}, 32'(rx_q[0]), 32'h41);
    for (int i = 0; i < FLEN; i++) begin
      x = x ^ exp_buf[i];
      chk($sformatf("%s_byte%0d", tag, i + 1), 32'(rx_q[i + 1]), 32'(exp_buf[i]));
    end
`ifdef FRAME_TX_CHECKSUM_EN
    chk({tag, "_checksum"}, 32'(rx_q[FLEN + 1]), 32'(x));
`endif
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : main
    int t0;
    int lat;
    int d0;

    vecs[0] = '{addr: 4'd0,  data: 8'hFF, wire_pos: 1,  exp_byte: 8'hFF};
    vecs[1] = '{addr: 4'd15, data: 8'h81, wire_pos: 16, exp_byte: 8'h81};
    vecs[2] = '{addr: 4'd3,  data: 8'hA5, wire_pos: 4,  exp_byte: 8'hA5};
    vecs[3] = '{addr: 4'd7,  data: 8'h3C, wire_pos: 8,  exp_byte: 8'h3C};
    vecs[4] = '{addr: 4'd8,  data: 8'h01, wire_pos: 9,  exp_byte: 8'h01};
    for (int i = 0; i < FLEN; i++) exp_buf[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // All-zero buffer frame
    d0 = done_cnt;
    rx_q.delete();
    start_send(1'b0, 4'd0, 8'h00, t0);
    wait_done(t0, lat);
    check_frame("zero", lat);
    chk("zero_done_once", 32'(done_cnt - d0), 32'd1);

    // Table-driven writes, then a frame
    for (int i = 0; i < 5; i++) wr_slot(vecs[i].addr, vecs[i].data);
    rx_q.delete();
    start_send(1'b0, 4'd0, 8'h00, t0);
    wait_done(t0, lat);
    for (int i = 0; i < 5; i++)
      chk($sformatf("vec%0d_wire%0d", i, vecs[i].wire_pos), 32'(rx_q[vecs[i].wire_pos]), 32'(vecs[i].exp_byte));
    chk("vec_untouched_slot1", 32'(rx_q[2]), 32'h00);
    check_frame("table", lat);

    // Write and i_send while busy are both ignored
    d0 = done_cnt;
    rx_q.delete();
    start_send(1'b0, 4'd0, 8'h00, t0);
    repeat (100) @(negedge clk);
    chk("midframe_busy", 32'(busy), 32'd1);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h55; send = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; send = 1'b0;
    wait_done(t0, lat);
    repeat (200) @(negedge clk);
    chk("midframe_slot3_old", 32'(rx_q[4]), 32'hA5);
    chk("midframe_done_once", 32'(done_cnt - d0), 32'd1);
    chk("midframe_idle_busy", 32'(busy), 32'd0);
    check_frame("midframe", lat);

    // Same-cycle write and send in IDLE: new byte goes out
    rx_q.delete();
    start_send(1'b1, 4'd5, 8'h77, t0);
    wait_done(t0, lat);
    chk("samecyc_slot5", 32'(rx_q[6]), 32'h77);
    chk("samecyc_slot3_kept", 32'(rx_q[4]), 32'hA5);
    check_frame("samecyc", lat);

    // Reset during payload byte 5 aborts the frame
    d0 = done_cnt;
    start_send(1'b0, 4'd0, 8'h00, t0);
    repeat (6 * 10 * BAUD + 2 * BAUD) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_tx_idle", 32'(tx), 32'd1);
    $display("frame abort: reset applied mid-payload");
    rx_q.delete();
    start_send(1'b0, 4'd0, 8'h00, t0);
    wait_done(t0, lat);
    check_frame("after_abort", lat);

    // Payload 0x01..0x10 (checksum of these bytes is 0x10)
    for (int i = 0; i < FLEN; i++) wr_slot(4'(i), 8'(i + 1));
    rx_q.delete();
    start_send(1'b0, 4'd0, 8'h00, t0);
    wait_done(t0, lat);
    chk("ramp_first", 32'(rx_q[1]), 32'h01);
    chk("ramp_last", 32'(rx_q[NBYTES - 1]), 32'h10);
    check_frame("ramp", lat);

    chk("done_busy_overlap", 32'(overlap_cnt), 32'd0);
    chk("rx_stop_bits", 32'(rx_frame_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
